control_unit: RTL and testbench

Hardwired Mini SRC control sequencer that drives every strobe of the `datapath` block. It fetches an instruction through PC/MAR/RAM/MDR into IR, decodes `IR[31:27]`, and steps through the execute T-states, reading IR and CON_out as its only datapath inputs. Each instruction takes between 4 and 8 clocks; `halt` parks the sequencer until reset.

---
 rtl/mini_src_pkg.sv | 96 +++++++++
 rtl/control_unit.sv | 167 ++++++++++++++++
 tb/tb_control_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mini_src_pkg.sv
// Shared encodings for the Mini SRC control sequencer: opcodes, ALU codes,
// bus sources and the T-state enum, plus per-opcode decode helpers.
package mini_src_pkg;

  localparam int unsigned OP_W    = 5;
  localparam int unsigned ALU_W   = 4;
  localparam int unsigned BUS_W   = 5;
  localparam int unsigned STATE_W = 4;

  localparam logic [OP_W-1:0] OP_LD   = 5'd0;
  localparam logic [OP_W-1:0] OP_LDI  = 5'd1;
  localparam logic [OP_W-1:0] OP_ST   = 5'd2;
  localparam logic [OP_W-1:0] OP_ADD  = 5'd3;
  localparam logic [OP_W-1:0] OP_SUB  = 5'd4;
  localparam logic [OP_W-1:0] OP_AND  = 5'd5;
  localparam logic [OP_W-1:0] OP_OR   = 5'd6;
  localparam logic [OP_W-1:0] OP_ROR  = 5'd7;
  localparam logic [OP_W-1:0] OP_ROL  = 5'd8;
  localparam logic [OP_W-1:0] OP_SHR  = 5'd9;
  localparam logic [OP_W-1:0] OP_SHRA = 5'd10;
  localparam logic [OP_W-1:0] OP_SHL  = 5'd11;
  localparam logic [OP_W-1:0] OP_ADDI = 5'd12;
  localparam logic [OP_W-1:0] OP_ANDI = 5'd13;
  localparam logic [OP_W-1:0] OP_ORI  = 5'd14;
  localparam logic [OP_W-1:0] OP_DIV  = 5'd15;
  localparam logic [OP_W-1:0] OP_MUL  = 5'd16;
  localparam logic [OP_W-1:0] OP_NEG  = 5'd17;
  localparam logic [OP_W-1:0] OP_NOT  = 5'd18;
  localparam logic [OP_W-1:0] OP_BR   = 5'd19;
  localparam logic [OP_W-1:0] OP_JR   = 5'd20;
  localparam logic [OP_W-1:0] OP_JAL  = 5'd21;
  localparam logic [OP_W-1:0] OP_IN   = 5'd22;
  localparam logic [OP_W-1:0] OP_OUT  = 5'd23;
  localparam logic [OP_W-1:0] OP_MFHI = 5'd24;
  localparam logic [OP_W-1:0] OP_MFLO = 5'd25;
  localparam logic [OP_W-1:0] OP_NOP  = 5'd26;
  localparam logic [OP_W-1:0] OP_HALT = 5'd27;

  localparam logic [ALU_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALU_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALU_W-1:0] ALU_ROR  = 4'd4;
  localparam logic [ALU_W-1:0] ALU_ROL  = 4'd5;
  localparam logic [ALU_W-1:0] ALU_SHR  = 4'd6;
  localparam logic [ALU_W-1:0] ALU_SHRA = 4'd7;
  localparam logic [ALU_W-1:0] ALU_SHL  = 4'd8;
  localparam logic [ALU_W-1:0] ALU_DIV  = 4'd9;
  localparam logic [ALU_W-1:0] ALU_MUL  = 4'd10;
  localparam logic [ALU_W-1:0] ALU_NEG  = 4'd11;
  localparam logic [ALU_W-1:0] ALU_NOT  = 4'd12;

  localparam logic [BUS_W-1:0] BUS_HI     = 5'd16;
  localparam logic [BUS_W-1:0] BUS_LO     = 5'd17;
  localparam logic [BUS_W-1:0] BUS_ZHI    = 5'd18;
  localparam logic [BUS_W-1:0] BUS_ZLO    = 5'd19;
  localparam logic [BUS_W-1:0] BUS_PC     = 5'd20;
  localparam logic [BUS_W-1:0] BUS_MDR    = 5'd21;
  localparam logic [BUS_W-1:0] BUS_INPORT = 5'd22;

  typedef enum logic [STATE_W-1:0] {
    ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_t;

  // Final T-state index of each opcode; unknown opcodes behave as nop.
  function automatic logic [2:0] last_tstate(input logic [OP_W-1:0] op);
    case (op)
      OP_NEG, OP_NOT, OP_JAL, OP_IN:                       return 3'd4;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
      OP_SHR, OP_SHRA, OP_SHL, OP_ADDI, OP_ANDI, OP_ORI,
      OP_LDI:                                              return 3'd5;
      OP_ST, OP_MUL, OP_DIV:                               return 3'd6;
      OP_LD, OP_BR:                                        return 3'd7;
      default:                                             return 3'd3;
    endcase
  endfunction

  function automatic logic [ALU_W-1:0] alu_code(input logic [OP_W-1:0] op);
    case (op)
      OP_SUB:           return ALU_SUB;
      OP_AND, OP_ANDI:  return ALU_AND;
      OP_OR, OP_ORI:    return ALU_OR;
      OP_ROR:           return ALU_ROR;
      OP_ROL:           return ALU_ROL;
      OP_SHR:           return ALU_SHR;
      OP_SHRA:          return ALU_SHRA;
      OP_SHL:           return ALU_SHL;
      OP_DIV:           return ALU_DIV;
      OP_MUL:           return ALU_MUL;
      OP_NEG:           return ALU_NEG;
      OP_NOT:           return ALU_NOT;
      default:          return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_unit.sv
// Hardwired Mini SRC sequencer: fetch in T0-T2, opcode-specific execute in
// T3-T7, strobes decoded from the T-state and IR, HALT parks until clear.
module control_unit
  import mini_src_pkg::*;
(
  input  logic              clock,
  input  logic              clear,
  input  logic [31:0]       IR,
  input  logic              CON_out,
  output logic              run,
  output logic [BUS_W-1:0]  BusDataSelect,
  output logic [ALU_W-1:0]  ALU_op,
  output logic              incPC, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR,
  output logic              Gra, Grb, Grc, Rin_en, Rout_en, BAout, imm_sel, MDR_read,
  output logic              ram_read, ram_write, CON_enable, RA_en, e_Out, e_IN
);

  state_t          state, state_nx;
  logic [OP_W-1:0] op;
  logic [3:0]      ra, rb, rc;
  logic [2:0]      tstate;
  logic            unused_ir;

  assign op        = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];
  assign tstate    = 3'(state);

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= ST_T0;
      run   <= 1'b1;
    end else begin
      state <= state_nx;
      run   <= (state_nx != ST_HALT);
    end
  end

  // Opcode is only consulted from T3 on, once IR holds the fetched word.
  always_comb begin
    state_nx = state;
    case (state)
      ST_T0:   state_nx = ST_T1;
      ST_T1:   state_nx = ST_T2;
      ST_T2:   state_nx = ST_T3;
      ST_HALT: state_nx = ST_HALT;
      default: begin
        if (state == ST_T3 && op == OP_HALT)   state_nx = ST_HALT;
        else if (tstate >= last_tstate(op))    state_nx = ST_T0;
        else                                   state_nx = state_t'(4'(state) + 4'd1);
      end
    endcase
  end

  always_comb begin
    BusDataSelect = '0;
    ALU_op     = ALU_ADD;
    incPC      = 1'b0; e_PC    = 1'b0; e_IR     = 1'b0; e_Y      = 1'b0;
    e_Z        = 1'b0; e_HI    = 1'b0; e_LO     = 1'b0; e_MDR    = 1'b0;
    e_MAR      = 1'b0; Gra     = 1'b0; Grb      = 1'b0; Grc      = 1'b0;
    Rin_en     = 1'b0; Rout_en = 1'b0; BAout    = 1'b0; imm_sel  = 1'b0;
    MDR_read   = 1'b0; ram_read = 1'b0; ram_write = 1'b0; CON_enable = 1'b0;
    RA_en      = 1'b0; e_Out   = 1'b0; e_IN     = 1'b0;
    if (!clear) begin
      case (state)
        ST_T0: begin BusDataSelect = BUS_PC; e_MAR = 1'b1; incPC = 1'b1; end
        ST_T1: begin ram_read = 1'b1; MDR_read = 1'b1; e_MDR = 1'b1; end
        ST_T2: begin BusDataSelect = BUS_MDR; e_IR = 1'b1; end
        ST_HALT: ;
        default: begin
          case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL: begin
              case (state)
                ST_T3: begin Grb = 1'b1; Rout_en = 1'b1; BusDataSelect = 5'(rb); e_Y = 1'b1; end
                ST_T4: begin Grc = 1'b1; Rout_en = 1'b1; BusDataSelect = 5'(rc);
                             ALU_op = alu_code(op); e_Z = 1'b1; end
                ST_T5: begin BusDataSelect = BUS_ZLO; Gra = 1'b1; Rin_en = 1'b1; end
                default: ;
              endcase
            end
            OP_NEG, OP_NOT: begin
              case (state)
                ST_T3: begin Grb = 1'b1; Rout_en = 1'b1; BusDataSelect = 5'(rb);
                             ALU_op = alu_code(op); e_Z = 1'b1; end
                ST_T4: begin BusDataSelect = BUS_ZLO; Gra = 1'b1; Rin_en = 1'b1; end
                default: ;
              endcase
            end
            // Immediate and memory-address ops share the Rb + imm address phase.
            OP_ADDI, OP_ANDI, OP_ORI, OP_LDI, OP_LD, OP_ST: begin
              case (state)
                ST_T3: begin Grb = 1'b1; Rout_en = 1'b1; BusDataSelect = 5'(rb); e_Y = 1'b1;
                             BAout = (op == OP_LDI || op == OP_LD || op == OP_ST); end
                ST_T4: begin imm_sel = 1'b1; ALU_op = alu_code(op); e_Z = 1'b1; end
                ST_T5: begin
                  BusDataSelect = BUS_ZLO;
                  if (op == OP_LD || op == OP_ST) e_MAR = 1'b1;
                  else begin Gra = 1'b1; Rin_en = 1'b1; end
                end
                ST_T6: begin
                  if (op == OP_LD) begin ram_read = 1'b1; MDR_read = 1'b1; e_MDR = 1'b1; end
                  else begin Gra = 1'b1; Rout_en = 1'b1; BusDataSelect = 5'(ra); ram_write = 1'b1; end
                end
                ST_T7: begin BusDataSelect = BUS_MDR; Gra = 1'b1; Rin_en = 1'b1; end
                default: ;
              endcase
            end
            OP_MUL, OP_DIV: begin
              case (state)
                ST_T3: begin Gra = 1'b1; Rout_en = 1'b1; BusDataSelect = 5'(ra); e_Y = 1'b1; end
                ST_T4: begin Grb = 1'b1; Rout_en = 1'b1; BusDataSelect = 5'(rb);
                             ALU_op = alu_code(op); e_Z = 1'b1; end
                ST_T5: begin BusDataSelect = BUS_ZLO; e_LO = 1'b1; end
                ST_T6: begin BusDataSelect = BUS_ZHI; e_HI = 1'b1; end
                default: ;
              endcase
            end
            OP_BR: begin
              case (state)
                ST_T3: begin Gra = 1'b1; Rout_en = 1'b1; BusDataSelect = 5'(ra); RA_en = 1'b1; end
                ST_T4: CON_enable = 1'b1;
                ST_T5: begin BusDataSelect = BUS_PC; e_Y = 1'b1; end
                ST_T6: begin imm_sel = 1'b1; ALU_op = ALU_ADD; e_Z = 1'b1; end
                ST_T7: begin BusDataSelect = BUS_ZLO; e_PC = CON_out; end
                default: ;
              endcase
            end
            OP_JR: begin
              if (state == ST_T3) begin
                Gra = 1'b1; Rout_en = 1'b1; BusDataSelect = 5'(ra); e_PC = 1'b1;
              end
            end
            OP_JAL: begin
              case (state)
                ST_T3: begin BusDataSelect = BUS_PC; Grb = 1'b1; Rin_en = 1'b1; end
                ST_T4: begin Gra = 1'b1; Rout_en = 1'b1; BusDataSelect = 5'(ra); e_PC = 1'b1; end
                default: ;
              endcase
            end
            OP_IN: begin
              case (state)
                ST_T3: e_IN = 1'b1;
                ST_T4: begin BusDataSelect = BUS_INPORT; Gra = 1'b1; Rin_en = 1'b1; end
                default: ;
              endcase
            end
            OP_OUT: begin
              if (state == ST_T3) begin
                Gra = 1'b1; Rout_en = 1'b1; BusDataSelect = 5'(ra); e_Out = 1'b1;
              end
            end
            OP_MFHI, OP_MFLO: begin
              if (state == ST_T3) begin
                BusDataSelect = (op == OP_MFHI) ? BUS_HI : BUS_LO;
                Gra = 1'b1; Rin_en = 1'b1;
              end
            end
            default: ;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Cycle-by-cycle vector bench for control_unit: each record gives the inputs
// for one clock and the bus select, ALU code and strobe set expected in it.
module tb_control_unit;

  logic        clock, clear, CON_out;
  logic [31:0] IR;
  logic        run;
  logic [4:0]  BusDataSelect;
  logic [3:0]  ALU_op;
  logic        incPC, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR;
  logic        Gra, Grb, Grc, Rin_en, Rout_en, BAout, imm_sel, MDR_read;
  logic        ram_read, ram_write, CON_enable, RA_en, e_Out, e_IN;

  control_unit dut (
    .clock(clock), .clear(clear), .IR(IR), .CON_out(CON_out), .run(run),
    .BusDataSelect(BusDataSelect), .ALU_op(ALU_op),
    .incPC(incPC), .e_PC(e_PC), .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z), .e_HI(e_HI),
    .e_LO(e_LO), .e_MDR(e_MDR), .e_MAR(e_MAR),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin_en(Rin_en), .Rout_en(Rout_en),
    .BAout(BAout), .imm_sel(imm_sel), .MDR_read(MDR_read),
    .ram_read(ram_read), .ram_write(ram_write), .CON_enable(CON_enable),
    .RA_en(RA_en), .e_Out(e_Out), .e_IN(e_IN)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [23:0] M_IN   = 24'(1) << 0;
  localparam logic [23:0] M_OUT  = 24'(1) << 1;
  localparam logic [23:0] M_RAEN = 24'(1) << 2;
  localparam logic [23:0] M_CON  = 24'(1) << 3;
  localparam logic [23:0] M_RAMW = 24'(1) << 4;
  localparam logic [23:0] M_RAMR = 24'(1) << 5;
  localparam logic [23:0] M_MDRR = 24'(1) << 6;
  localparam logic [23:0] M_IMM  = 24'(1) << 7;
  localparam logic [23:0] M_BA   = 24'(1) << 8;
  localparam logic [23:0] M_ROUT = 24'(1) << 9;
  localparam logic [23:0] M_RIN  = 24'(1) << 10;
  localparam logic [23:0] M_GRC  = 24'(1) << 11;
  localparam logic [23:0] M_GRB  = 24'(1) << 12;
  localparam logic [23:0] M_GRA  = 24'(1) << 13;
  localparam logic [23:0] M_MAR  = 24'(1) << 14;
  localparam logic [23:0] M_MDR  = 24'(1) << 15;
  localparam logic [23:0] M_LO   = 24'(1) << 16;
  localparam logic [23:0] M_HI   = 24'(1) << 17;
  localparam logic [23:0] M_Z    = 24'(1) << 18;
  localparam logic [23:0] M_Y    = 24'(1) << 19;
  localparam logic [23:0] M_IR   = 24'(1) << 20;
  localparam logic [23:0] M_PC   = 24'(1) << 21;
  localparam logic [23:0] M_INC  = 24'(1) << 22;
  localparam logic [23:0] M_RUN  = 24'(1) << 23;

  localparam logic [31:0] JUNK = 32'hFFFF_FFFF;

  logic [23:0] obs;
  assign obs = {run, incPC, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR,
                Gra, Grb, Grc, Rin_en, Rout_en, BAout, imm_sel, MDR_read,
                ram_read, ram_write, CON_enable, RA_en, e_Out, e_IN};

  typedef struct {
    logic        clr;
    logic [31:0] ir;
    logic        con;
    logic [4:0]  sel;
    logic [3:0]  alu;
    logic [23:0] str;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   waited = 0;

  function automatic logic [31:0] mk(input int op, input int ra, input int rb,
                                     input int rc, input int imm);
    return {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'(imm)};
  endfunction

  task automatic add_vec(input logic clr, input logic [31:0] ir, input logic con,
                         input int sel, input int alu, input logic [23:0] str);
    vec_t v;
    v.clr = clr; v.ir = ir; v.con = con;
    v.sel = 5'(sel); v.alu = 4'(alu); v.str = str;
    vecs.push_back(v);
  endtask

  task automatic ex(input logic [31:0] ir, input int sel, input int alu,
                    input logic [23:0] str);
    add_vec(1'b0, ir, 1'b0, sel, alu, str | M_RUN);
  endtask

  // IR is deliberately junk during fetch: decode must ignore it there.
  task automatic fetch();
    ex(JUNK, 20, 0, M_INC | M_MAR);
    ex(JUNK, 0,  0, M_RAMR | M_MDRR | M_MDR);
    ex(JUNK, 21, 0, M_IR);
  endtask

  logic [31:0] i_add, i_sub, i_neg, i_ori, i_ld, i_st, i_mul, i_br, i_jr, i_jal;
  logic [31:0] i_in, i_out, i_mfhi, i_mflo, i_nop, i_bad, i_halt;

  initial begin
    i_add  = 32'h1989_0000;                 // add R3,R1,R2
    i_sub  = mk(4, 5, 6, 7, 0);
    i_neg  = mk(17, 4, 6, 0, 0);
    i_ori  = mk(14, 1, 2, 0, 16);
    i_ld   = mk(0, 2, 0, 0, 'h95);          // ld R2,0x95(R0)
    i_st   = mk(2, 8, 4, 0, 'h20);
    i_mul  = mk(16, 3, 1, 0, 0);
    i_br   = mk(19, 5, 3, 0, 'h10);
    i_jr   = mk(20, 6, 0, 0, 0);
    i_jal  = mk(21, 7, 15, 0, 0);
    i_in   = mk(22, 10, 0, 0, 0);
    i_out  = mk(23, 11, 0, 0, 0);
    i_mfhi = mk(24, 9, 0, 0, 0);
    i_mflo = mk(25, 12, 0, 0, 0);
    i_nop  = mk(26, 3, 3, 3, 0);
    i_bad  = mk(30, 3, 3, 3, 0);
    i_halt = mk(27, 0, 0, 0, 0);

    fetch(); ex(i_add, 1, 0, M_GRB | M_ROUT | M_Y);
             ex(i_add, 2, 0, M_GRC | M_ROUT | M_Z);
             ex(i_add, 19, 0, M_GRA | M_RIN);
    fetch(); ex(i_sub, 6, 0, M_GRB | M_ROUT | M_Y);
             ex(i_sub, 7, 1, M_GRC | M_ROUT | M_Z);
             ex(i_sub, 19, 0, M_GRA | M_RIN);
    fetch(); ex(i_neg, 6, 11, M_GRB | M_ROUT | M_Z);
             ex(i_neg, 19, 0, M_GRA | M_RIN);
    fetch(); ex(i_ori, 2, 0, M_GRB | M_ROUT | M_Y);
             ex(i_ori, 0, 3, M_IMM | M_Z);
             ex(i_ori, 19, 0, M_GRA | M_RIN);
    fetch(); ex(i_ld, 0, 0, M_GRB | M_ROUT | M_BA | M_Y);
             ex(i_ld, 0, 0, M_IMM | M_Z);
             ex(i_ld, 19, 0, M_MAR);
             ex(i_ld, 0, 0, M_RAMR | M_MDRR | M_MDR);
             ex(i_ld, 21, 0, M_GRA | M_RIN);
    fetch(); ex(i_st, 4, 0, M_GRB | M_ROUT | M_BA | M_Y);
             ex(i_st, 0, 0, M_IMM | M_Z);
             ex(i_st, 19, 0, M_MAR);
             ex(i_st, 8, 0, M_GRA | M_ROUT | M_RAMW);
    fetch(); ex(i_mul, 3, 0, M_GRA | M_ROUT | M_Y);
             ex(i_mul, 1, 10, M_GRB | M_ROUT | M_Z);
             ex(i_mul, 19, 0, M_LO);
             ex(i_mul, 18, 0, M_HI);
    // br not taken: CON_out high outside T7 must not matter.
    fetch(); add_vec(1'b0, i_br, 1'b1, 5, 0, M_RUN | M_GRA | M_ROUT | M_RAEN);
             add_vec(1'b0, i_br, 1'b1, 0, 0, M_RUN | M_CON);
             add_vec(1'b0, i_br, 1'b1, 20, 0, M_RUN | M_Y);
             add_vec(1'b0, i_br, 1'b1, 0, 0, M_RUN | M_IMM | M_Z);
             add_vec(1'b0, i_br, 1'b0, 19, 0, M_RUN);
    fetch(); ex(i_br, 5, 0, M_GRA | M_ROUT | M_RAEN);
             ex(i_br, 0, 0, M_CON);
             ex(i_br, 20, 0, M_Y);
             ex(i_br, 0, 0, M_IMM | M_Z);
             add_vec(1'b0, i_br, 1'b1, 19, 0, M_RUN | M_PC);
    fetch(); ex(i_jr, 6, 0, M_GRA | M_ROUT | M_PC);
    fetch(); ex(i_jal, 20, 0, M_GRB | M_RIN);
             ex(i_jal, 7, 0, M_GRA | M_ROUT | M_PC);
    fetch(); ex(i_in, 0, 0, M_IN);
             ex(i_in, 22, 0, M_GRA | M_RIN);
    fetch(); ex(i_out, 11, 0, M_GRA | M_ROUT | M_OUT);
    fetch(); ex(i_mfhi, 16, 0, M_GRA | M_RIN);
    fetch(); ex(i_mflo, 17, 0, M_GRA | M_RIN);
    fetch(); ex(i_nop, 0, 0, '0);
    fetch(); ex(i_bad, 0, 0, '0);
    // clear during add T4: strobes gated, fetch restarts next cycle
    fetch(); ex(i_add, 1, 0, M_GRB | M_ROUT | M_Y);
             add_vec(1'b1, i_add, 1'b0, 0, 0, M_RUN);
    fetch(); ex(i_nop, 0, 0, '0);
    // halt parks with run low; only clear restarts fetch
    fetch(); ex(i_halt, 0, 0, '0);
    for (int k = 0; k < 20; k++) add_vec(1'b0, (k < 10) ? i_halt : i_add, 1'b1, 0, 0, '0);
    add_vec(1'b1, i_halt, 1'b0, 0, 0, '0);
    fetch(); ex(i_nop, 0, 0, '0);
    fetch();

    clear = 1'b1; IR = '0; CON_out = 1'b0;

    // reset state: clear edge loads T0 with run high and all strobes gated
    @(posedge clock);
    #1;
    checks++;
    if (run !== 1'b1 || BusDataSelect !== 5'd0 || ALU_op !== 4'd0 || obs !== M_RUN) begin
      errors++;
      $display("FAIL reset state: run=%b sel=%0d alu=%0d strobes=%06h",
               run, BusDataSelect, ALU_op, obs);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clock);
      #1;
      clear   = vecs[i].clr;
      IR      = vecs[i].ir;
      CON_out = vecs[i].con;
      @(negedge clock);
      checks++;
      if (BusDataSelect !== vecs[i].sel || ALU_op !== vecs[i].alu || obs !== vecs[i].str) begin
        errors++;
        $display("FAIL vec%0d sel/alu/strobes: got %0d/%0d/%06h want %0d/%0d/%06h",
                 i, BusDataSelect, ALU_op, obs, vecs[i].sel, vecs[i].alu, vecs[i].str);
      end
    end

    // bounded wait for halt to park the sequencer
    clear = 1'b0; IR = i_halt; CON_out = 1'b0;
    waited = 0;
    while (waited < 10 && run !== 1'b0) begin
      @(posedge clock);
      #1;
      waited++;
    end
    checks++;
    if (run !== 1'b0 || obs !== '0 || BusDataSelect !== 5'd0) begin
      errors++;
      $display("FAIL halt wait expired after %0d cycles: run=%b strobes=%06h sel=%0d",
               waited, run, obs, BusDataSelect);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
